// File: rtl/kamus_mem_stage.sv
// kamus RV32I memory-access stage: L1D req/gnt/rvalid sequencing, store lane
// steering, load alignment/extension, misalignment report and the MEM/WB register.
module kamus_mem_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_exmem_reg_i,
  input  logic [31:0] alu_exmem_reg_i,
  input  logic [31:0] rs2_data_exmem_reg_i,
  input  logic        mem_rd_en_exmem_reg_i,
  input  logic        mem_wr_en_exmem_reg_i,
  input  logic [2:0]  funct3_exmem_reg_i,
  input  logic        regfile_wr_en_exmem_reg_i,
  input  logic [1:0]  wb_mux_sel_exmem_reg_i,
  input  logic [4:0]  rd_addr_exmem_reg_i,
  output logic        l1d_req_o,
  output logic        l1d_we_o,
  output logic [31:0] l1d_addr_o,
  output logic [3:0]  l1d_be_o,
  output logic [31:0] l1d_wr_data_o,
  input  logic        l1d_gnt_i,
  input  logic        l1d_rvalid_i,
  input  logic [31:0] l1d_rd_data_i,
  output logic        stall_o,
  output logic        regfile_wr_en_memwb_reg_o,
  output logic [31:0] alu_memwb_reg_o,
  output logic [31:0] l1d_rd_data_memwb_reg_o,
  output logic [1:0]  wb_mux_sel_memwb_reg_o,
  output logic [4:0]  rd_addr_memwb_reg_o,
  output logic        misaligned_o,
  output logic [31:0] misaligned_addr_o
);

  // state    | meaning
  // IDLE     | no access outstanding; aligned memory op requests combinationally
  // REQ      | request presented, gnt not yet received
  // WAIT_RSP | load granted, awaiting rvalid
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  off;
  logic        mem_op, is_half, is_word, misaligned, access;
  logic        store_done, load_done;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign off     = alu_exmem_reg_i[1:0];
  assign mem_op  = valid_exmem_reg_i & (mem_rd_en_exmem_reg_i | mem_wr_en_exmem_reg_i);
  assign is_half = (funct3_exmem_reg_i == 3'b001) |
                   ((funct3_exmem_reg_i == 3'b101) & mem_rd_en_exmem_reg_i);
  assign is_word = (funct3_exmem_reg_i == 3'b010);
  assign misaligned = (state_q == IDLE) & mem_op &
                      ((is_half & off[0]) | (is_word & (off != 2'b00)));
  // Gated by reset so no request leaks out while the cache is also held in reset.
  assign access  = mem_op & ~misaligned & rst_ni;

  always_comb begin
    state_d   = state_q;
    l1d_req_o = 1'b0;
    stall_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          l1d_req_o = 1'b1;
          stall_o   = ~(mem_wr_en_exmem_reg_i & l1d_gnt_i);
          if (l1d_gnt_i) state_d = mem_wr_en_exmem_reg_i ? IDLE : WAIT_RSP;
          else           state_d = REQ;
        end
      end
      REQ: begin
        l1d_req_o = rst_ni;
        stall_o   = ~(mem_wr_en_exmem_reg_i & l1d_gnt_i);
        if (l1d_gnt_i) state_d = mem_wr_en_exmem_reg_i ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        stall_o = ~l1d_rvalid_i;
        if (l1d_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign store_done = (((state_q == IDLE) & access) | (state_q == REQ)) &
                      mem_wr_en_exmem_reg_i & l1d_gnt_i;
  assign load_done  = (state_q == WAIT_RSP) & l1d_rvalid_i;

  assign l1d_we_o   = mem_wr_en_exmem_reg_i;
  assign l1d_addr_o = {alu_exmem_reg_i[31:2], 2'b00};

  always_comb begin
    l1d_be_o      = 4'b1111;
    l1d_wr_data_o = rs2_data_exmem_reg_i;
    case (funct3_exmem_reg_i)
      3'b000: begin
        l1d_be_o      = 4'b0001 << off;
        l1d_wr_data_o = {4{rs2_data_exmem_reg_i[7:0]}};
      end
      3'b001: begin
        l1d_be_o      = off[1] ? 4'b1100 : 4'b0011;
        l1d_wr_data_o = {2{rs2_data_exmem_reg_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    ld_byte = l1d_rd_data_i[7:0];
      2'd1:    ld_byte = l1d_rd_data_i[15:8];
      2'd2:    ld_byte = l1d_rd_data_i[23:16];
      default: ld_byte = l1d_rd_data_i[31:24];
    endcase
    ld_half = off[1] ? l1d_rd_data_i[31:16] : l1d_rd_data_i[15:0];
    case (funct3_exmem_reg_i)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = l1d_rd_data_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regfile_wr_en_memwb_reg_o <= 1'b0;
      alu_memwb_reg_o           <= 32'h0;
      l1d_rd_data_memwb_reg_o   <= 32'h0;
      wb_mux_sel_memwb_reg_o    <= 2'b00;
      rd_addr_memwb_reg_o       <= 5'd0;
      misaligned_o              <= 1'b0;
      misaligned_addr_o         <= 32'h0;
    end else if (stall_o || store_done) begin
      regfile_wr_en_memwb_reg_o <= 1'b0;
      misaligned_o              <= 1'b0;
    end else if (misaligned) begin
      regfile_wr_en_memwb_reg_o <= 1'b0;
      misaligned_o              <= 1'b1;
      misaligned_addr_o         <= alu_exmem_reg_i;
    end else begin
      // Load completion and plain ALU ops both forward the writeback controls.
      regfile_wr_en_memwb_reg_o <= valid_exmem_reg_i & regfile_wr_en_exmem_reg_i;
      alu_memwb_reg_o           <= alu_exmem_reg_i;
      wb_mux_sel_memwb_reg_o    <= wb_mux_sel_exmem_reg_i;
      rd_addr_memwb_reg_o       <= rd_addr_exmem_reg_i;
      misaligned_o              <= 1'b0;
      if (load_done) l1d_rd_data_memwb_reg_o <= ld_data;
    end
  end

endmodule

// File: tb/tb_kamus_mem_stage.sv
// Self-checking bench for kamus_mem_stage: directed cases plus randomized ops
// against a transaction-level model with an emulated L1D (random gnt/rvalid delays).
module tb_kamus_mem_stage;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid, rd_en, wr_en, rf_wen;
  logic [31:0] alu, rs2, rdata;
  logic [2:0]  f3;
  logic [1:0]  wbs;
  logic [4:0]  rd;
  logic        req, we, gnt, rvalid, stall;
  logic [31:0] addr_o, wdata;
  logic [3:0]  be;
  logic        wb_wen, mis;
  logic [31:0] wb_alu, wb_rdata, mis_addr;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;

  int n_chk = 0;
  int n_fail = 0;

  kamus_mem_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_exmem_reg_i(valid), .alu_exmem_reg_i(alu), .rs2_data_exmem_reg_i(rs2),
    .mem_rd_en_exmem_reg_i(rd_en), .mem_wr_en_exmem_reg_i(wr_en),
    .funct3_exmem_reg_i(f3), .regfile_wr_en_exmem_reg_i(rf_wen),
    .wb_mux_sel_exmem_reg_i(wbs), .rd_addr_exmem_reg_i(rd),
    .l1d_req_o(req), .l1d_we_o(we), .l1d_addr_o(addr_o), .l1d_be_o(be),
    .l1d_wr_data_o(wdata), .l1d_gnt_i(gnt), .l1d_rvalid_i(rvalid),
    .l1d_rd_data_i(rdata), .stall_o(stall),
    .regfile_wr_en_memwb_reg_o(wb_wen), .alu_memwb_reg_o(wb_alu),
    .l1d_rd_data_memwb_reg_o(wb_rdata), .wb_mux_sel_memwb_reg_o(wb_sel),
    .rd_addr_memwb_reg_o(wb_rd), .misaligned_o(mis), .misaligned_addr_o(mis_addr)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] fn, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = 8 * a[1:0];
    b  = 8'(w >> sh);
    h  = a[1] ? w[31:16] : w[15:0];
    case (fn)
      3'b000:  return 32'($signed(b));
      3'b100:  return 32'(b);
      3'b001:  return 32'($signed(h));
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  // One instruction through the stage; gd = cycles before gnt, rl = cycles from gnt to rvalid.
  task automatic run_op(input bit vld, input bit ld, input bit st, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] data, input logic [31:0] word,
                        input int gd, input int rl, input logic [4:0] rdi,
                        input logic [1:0] sel, input logic wen);
    bit is_mem, misal, done;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    is_mem = vld && (ld || st);
    misal  = is_mem && ((((fn == 3'b001) || (ld && fn == 3'b101)) && a[0]) ||
                        (fn == 3'b010 && a[1:0] != 2'b00));
    case (fn)
      3'b000:  begin exp_be = 4'(1 << a[1:0]); exp_wd = {4{data[7:0]}};  end
      3'b001:  begin exp_be = a[1] ? 4'hC : 4'h3; exp_wd = {2{data[15:0]}}; end
      default: begin exp_be = 4'hF; exp_wd = data; end
    endcase
    @(negedge clk_i);
    valid = vld; rd_en = ld; wr_en = st; f3 = fn; alu = a; rs2 = data;
    rd = rdi; wbs = sel; rf_wen = wen; rdata = word; gnt = 1'b0;
    rvalid = is_mem ? 1'b0 : 1'($urandom_range(0, 1));
    if (!is_mem || misal) begin
      #1;
      chk("nomem_req", req, 0);
      chk("nomem_stall", stall, 0);
      @(posedge clk_i); #1;
      chk("wb_wen", wb_wen, (misal || !vld) ? 0 : wen);
      chk("mis_flag", mis, misal);
      if (misal) chk("mis_addr", mis_addr, a);
      else if (vld) begin
        chk("wb_alu", wb_alu, a);
        chk("wb_rd", wb_rd, rdi);
        chk("wb_sel", wb_sel, sel);
      end
      return;
    end
    for (int c = 0; c <= gd + rl; c++) begin
      if (c > 0) @(negedge clk_i);
      gnt    = (c == gd);
      rvalid = ld && (c == gd + rl);
      #1;
      done = st ? (c == gd) : (c == gd + rl);
      chk("req", req, c <= gd);
      if (c <= gd) begin
        chk("addr", addr_o, {a[31:2], 2'b00});
        chk("we", we, st);
        if (st) begin
          chk("be", be, exp_be);
          chk("wdata", wdata, exp_wd);
        end
      end
      chk("stall", stall, !done);
      @(posedge clk_i); #1;
      if (done) break;
      chk("bubble_wen", wb_wen, 0);
    end
    chk("done_mis", mis, 0);
    if (st) chk("store_bubble", wb_wen, 0);
    else begin
      chk("ld_wen", wb_wen, wen);
      chk("ld_data", wb_rdata, exp_load(fn, a, word));
      chk("ld_rd", wb_rd, rdi);
      chk("ld_alu", wb_alu, a);
    end
  endtask

  initial begin
    logic [2:0] ldf [5];
    ldf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst_ni = 1'b0; valid = 0; rd_en = 0; wr_en = 0; f3 = 0; alu = 0; rs2 = 0;
    rd = 0; wbs = 0; rf_wen = 0; rdata = 0; gnt = 0; rvalid = 0;
    #12;
    chk("rst_req", req, 0);
    chk("rst_wen", wb_wen, 0);
    chk("rst_alu", wb_alu, 0);
    chk("rst_rdata", wb_rdata, 0);
    chk("rst_mis", mis, 0);
    chk("rst_mis_addr", mis_addr, 0);
    @(negedge clk_i); rst_ni = 1'b1;

    run_op(1, 0, 0, 3'b000, 32'h1234, 0, 0, 0, 0, 5'd5, 2'd0, 1);
    run_op(1, 1, 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 0, 1, 5'd6, 2'd1, 1);
    run_op(1, 0, 1, 3'b001, 32'h202, 32'hABCD_1234, 0, 3, 1, 5'd0, 2'd0, 0);
    run_op(1, 1, 0, 3'b010, 32'h5, 0, 0, 0, 1, 5'd7, 2'd1, 1);
    run_op(1, 1, 0, 3'b101, 32'h302, 0, 32'h8001_7FFF, 1, 2, 5'd8, 2'd1, 1);
    run_op(1, 1, 0, 3'b001, 32'h302, 0, 32'h8001_7FFF, 0, 1, 5'd9, 2'd1, 1);

    for (int i = 0; i < 300; i++) begin
      int k;
      bit ld, st;
      logic [2:0] fn;
      k  = $urandom_range(0, 9);
      ld = (k >= 2 && k <= 5);
      st = (k >= 6);
      fn = st ? 3'($urandom_range(0, 2)) : ldf[$urandom_range(0, 4)];
      run_op(k != 1, ld, st, fn, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3), 5'($urandom),
             2'($urandom), 1'($urandom));
    end

    // Reset while a load waits for its response; the late rvalid must be dropped.
    run_op(1, 0, 0, 3'b000, 32'hCAFE, 0, 0, 0, 0, 5'd3, 2'd2, 1);
    @(negedge clk_i);
    valid = 1; rd_en = 1; wr_en = 0; f3 = 3'b010; alu = 32'h400; rdata = 32'h1357_9BDF;
    gnt = 1; rvalid = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i); gnt = 0;
    #1; chk("wait_stall", stall, 1);
    rst_ni = 1'b0; #1;
    chk("rst_mid_req", req, 0);
    chk("rst_mid_wen", wb_wen, 0);
    chk("rst_mid_alu", wb_alu, 0);
    chk("rst_mid_rd", wb_rd, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; valid = 0; rvalid = 1;
    #1; chk("late_stall", stall, 0);
    @(posedge clk_i); #1;
    chk("late_wen", wb_wen, 0);
    chk("late_rdata", wb_rdata, 0);
    @(negedge clk_i); rvalid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
